// File: rtl/opll_write_scheduler_if.sv
// Bus between the Z80 write decode / tick source and the OPLL write scheduler.
// The scheduler attaches through the slave modport; the driving side uses master.
interface opll_write_scheduler_if #(
  parameter int DEPTH = 16
);
  logic                     tick_3m6;
  logic                     wr_req;
  logic                     wr_a;
  logic [7:0]               wr_data;
  logic                     ovf_clr;
  logic                     opll_cs_n;
  logic                     opll_a;
  logic [7:0]               opll_d;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     fifo_full;
  logic                     overflow;

  modport master (
    output tick_3m6, wr_req, wr_a, wr_data, ovf_clr,
    input  opll_cs_n, opll_a, opll_d, busy, fifo_level, fifo_full, overflow
  );

  modport slave (
    input  tick_3m6, wr_req, wr_a, wr_data, ovf_clr,
    output opll_cs_n, opll_a, opll_d, busy, fifo_level, fifo_full, overflow
  );
endinterface

// File: rtl/opll_write_scheduler.sv
// Buffers Z80 writes to the OPLL and replays them with YM2413 recovery spacing
// (address/data busy windows), paced by the 3.58 MHz tick enable.
module opll_write_scheduler #(
  parameter int DEPTH        = 16,
  parameter int STROBE_TICKS = 2,
  parameter int ADDR_WAIT    = 12,
  parameter int DATA_WAIT    = 84
) (
  input  logic                  clk,
  input  logic                  reset_n,
  opll_write_scheduler_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
  localparam logic [6:0]    STB_LIM    = 7'(STROBE_TICKS);
  localparam logic [6:0]    ADDR_LIM   = 7'((ADDR_WAIT < STROBE_TICKS) ? STROBE_TICKS : ADDR_WAIT);
  localparam logic [6:0]    DATA_LIM   = 7'((DATA_WAIT < STROBE_TICKS) ? STROBE_TICKS : DATA_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_WAIT} state_t;

  state_t        r_state, w_state_next;
  logic [8:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_overflow;
  logic [6:0]    r_cnt, w_cnt_next, w_cnt_inc, w_limit;
  logic          r_cs_n, w_cs_n_next;
  logic          r_a;
  logic [7:0]    r_d;
  logic          w_pop, w_push, w_drop, w_full;
  logic [8:0]    w_head;

  assign w_full  = (r_level == FULL_LEVEL);
  assign w_head  = r_mem[r_rd_ptr];
  assign w_limit = r_a ? DATA_LIM : ADDR_LIM;
  // A pop in the same clk frees the slot, so a push into a full FIFO is still accepted.
  assign w_push  = bus.wr_req && (!w_full || w_pop);
  assign w_drop  = bus.wr_req && w_full && !w_pop;
  assign w_cnt_inc = (bus.tick_3m6 && (r_cnt != 7'h7F)) ? r_cnt + 7'd1 : r_cnt;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cs_n_next  = r_cs_n;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cs_n_next = 1'b1;
        if (r_level != '0) begin
          w_pop        = 1'b1;
          w_cs_n_next  = 1'b0;
          w_cnt_next   = '0;
          w_state_next = S_STROBE;
        end
      end
      S_STROBE: begin
        w_cnt_next = w_cnt_inc;
        if (w_cnt_inc >= STB_LIM) begin
          w_cs_n_next  = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        // Count carries over from the strobe: the window is measured from strobe start.
        if (w_cnt_inc >= w_limit) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_cs_n_next  = 1'b1;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_cs_n     <= 1'b1;
      r_a        <= 1'b0;
      r_d        <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_cs_n  <= w_cs_n_next;
      if (w_pop) begin
        r_a      <= w_head[8];
        r_d      <= w_head[7:0];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LW'(1);
      end else if (w_pop && !w_push) begin
        r_level <= r_level - LW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (bus.ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {bus.wr_a, bus.wr_data};
    end
  end

  assign bus.opll_cs_n  = r_cs_n;
  assign bus.opll_a     = r_a;
  assign bus.opll_d     = r_d;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.fifo_level = r_level;
  assign bus.fifo_full  = w_full;
  assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_opll_write_scheduler.sv
// Scoreboard bench for opll_write_scheduler: queued writes must replay in order
// with the expected strobe width, busy window and strobe-to-strobe spacing.
module tb_opll_write_scheduler;
  localparam int DEPTH = 16;
  localparam int STB   = 2;
  localparam int AWAIT = 12;
  localparam int DWAIT = 84;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  opll_write_scheduler_if #(.DEPTH(DEPTH)) bus();

  opll_write_scheduler #(
    .DEPTH(DEPTH), .STROBE_TICKS(STB), .ADDR_WAIT(AWAIT), .DATA_WAIT(DWAIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int         errors = 0;
  int         checks = 0;
  logic [8:0] sb[$];
  int         starts = 0;
  int         last_spacing = 0;
  bit         tick_en = 1'b0;

  // One tick every 4 clks while enabled, driven on the falling edge.
  initial begin : tick_gen
    int div;
    div = 0;
    bus.tick_3m6 = 1'b0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      bus.tick_3m6 = tick_en && (div == 0);
    end
  end

  // Strobe monitor: pops the scoreboard at each strobe start, measures ticks.
  initial begin : monitor
    logic       prev_cs_n, prev_busy, cur_a, active;
    logic [8:0] exp_e;
    int         since;
    prev_cs_n = 1'b1; prev_busy = 1'b0; cur_a = 1'b0; active = 1'b0; since = 0;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        prev_cs_n = 1'b1; prev_busy = 1'b0; active = 1'b0; since = 0;
      end else begin
        if (active && bus.tick_3m6) since++;
        if (prev_cs_n && !bus.opll_cs_n) begin
          if (active) last_spacing = since;
          $display("strobe %0d: a=%0d d=0x%02h ticks_since_prev=%0d", starts, bus.opll_a, bus.opll_d, active ? since : -1);
          starts++; active = 1'b1; since = 0; cur_a = bus.opll_a;
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL strobe_unexpected: got a=%0d d=0x%02h, required no strobe", bus.opll_a, bus.opll_d);
          end else begin
            exp_e = sb.pop_front();
            if ({bus.opll_a, bus.opll_d} !== exp_e) begin
              errors++;
              $display("FAIL strobe_entry: got 0x%03h, required 0x%03h", {bus.opll_a, bus.opll_d}, exp_e);
            end
          end
        end
        if (!prev_cs_n && bus.opll_cs_n) begin
          checks++;
          if (since != STB) begin
            errors++;
            $display("FAIL strobe_width: got %0d ticks, required %0d", since, STB);
          end
        end
        if (prev_busy && !bus.busy) begin
          checks++;
          if (since != (cur_a ? DWAIT : AWAIT)) begin
            errors++;
            $display("FAIL busy_window: got %0d ticks, required %0d", since, cur_a ? DWAIT : AWAIT);
          end
        end
        prev_cs_n = bus.opll_cs_n;
        prev_busy = bus.busy;
      end
    end
  end

  task automatic push(input logic a, input logic [7:0] d, input bit accept);
    @(negedge clk);
    bus.wr_req = 1'b1; bus.wr_a = a; bus.wr_data = d;
    if (accept) sb.push_back({a, d});
  endtask

  task automatic release_req();
    @(negedge clk);
    bus.wr_req = 1'b0; bus.wr_a = 1'($urandom); bus.wr_data = 8'($urandom);
  endtask

  task automatic wait_starts(input int target, input string what);
    int n;
    n = 0;
    while (starts < target && n < 2000) begin @(negedge clk); n++; end
    if (starts < target) begin
      checks++; errors++;
      $display("FAIL %s_timeout: strobes=%0d, required %0d", what, starts, target);
    end
  endtask

  task automatic wait_idle(input int budget, input string what);
    int n;
    n = 0;
    while ((bus.busy || bus.fifo_level != 0) && n < budget) begin @(negedge clk); n++; end
    if (bus.busy || bus.fifo_level != 0) begin
      checks++; errors++;
      $display("FAIL %s_idle_timeout: busy=%0d level=%0d, required 0/0", what, bus.busy, bus.fifo_level);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.opll_cs_n !== 1'b1) begin errors++; $display("FAIL rst_cs_n: got %b, required 1", bus.opll_cs_n); end
    checks++; if (bus.opll_a !== 1'b0) begin errors++; $display("FAIL rst_a: got %b, required 0", bus.opll_a); end
    checks++; if (bus.opll_d !== 8'h00) begin errors++; $display("FAIL rst_d: got 0x%02h, required 0x00", bus.opll_d); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", bus.busy); end
    checks++; if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d, required 0", bus.fifo_level); end
    checks++; if (bus.fifo_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b, required 0", bus.fifo_full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b, required 0", bus.overflow); end
    reset_n = 1'b1;
    tick_en = 1'b1;
  endtask

  task automatic test_single();
    int s0;
    s0 = starts;
    push(1'b0, 8'h30, 1'b1);
    release_req();
    checks++; if (bus.opll_cs_n !== 1'b1) begin errors++; $display("FAIL single_lat1_cs_n: got %b, required 1", bus.opll_cs_n); end
    checks++; if (bus.fifo_level !== 5'd1) begin errors++; $display("FAIL single_level: got %0d, required 1", bus.fifo_level); end
    @(negedge clk);
    checks++; if (bus.opll_cs_n !== 1'b0) begin errors++; $display("FAIL single_lat2_cs_n: got %b, required 0", bus.opll_cs_n); end
    checks++; if (bus.opll_a !== 1'b0 || bus.opll_d !== 8'h30) begin errors++; $display("FAIL single_bus: got a=%b d=0x%02h, required a=0 d=0x30", bus.opll_a, bus.opll_d); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, required 1", bus.busy); end
    wait_idle(1000, "single");
    checks++; if (starts != s0 + 1) begin errors++; $display("FAIL single_count: got %0d strobes, required %0d", starts - s0, 1); end
  endtask

  task automatic test_burst();
    int s0;
    s0 = starts;
    push(1'b0, 8'h30, 1'b1);
    push(1'b1, 8'h1F, 1'b1);
    release_req();
    wait_starts(s0 + 2, "burst");
    checks++; if (last_spacing != AWAIT) begin errors++; $display("FAIL burst_addr_spacing: got %0d, required %0d", last_spacing, AWAIT); end
    push(1'b0, 8'h10, 1'b1);
    release_req();
    wait_starts(s0 + 3, "burst");
    checks++; if (last_spacing != DWAIT) begin errors++; $display("FAIL burst_data_spacing: got %0d, required %0d", last_spacing, DWAIT); end
    wait_idle(1000, "burst");
  endtask

  task automatic test_reset_mid();
    int n, s0;
    push(1'b0, 8'h10, 1'b1);
    release_req();
    n = 0;
    while (bus.opll_cs_n && n < 20) begin @(negedge clk); n++; end
    checks++; if (bus.opll_cs_n !== 1'b0) begin errors++; $display("FAIL rmid_strobe: got cs_n=%b, required 0", bus.opll_cs_n); end
    push(1'b1, 8'h44, 1'b0);
    reset_n = 1'b0;
    #1;
    checks++; if (bus.opll_cs_n !== 1'b1) begin errors++; $display("FAIL rmid_cs_n: got %b, required 1", bus.opll_cs_n); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, required 0", bus.busy); end
    checks++; if (bus.fifo_level !== 5'd0) begin errors++; $display("FAIL rmid_level: got %0d, required 0", bus.fifo_level); end
    release_req();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    s0 = starts;
    repeat (200) @(negedge clk);
    checks++; if (starts != s0 || bus.opll_cs_n !== 1'b1) begin errors++; $display("FAIL rmid_no_strobe: got %0d strobes cs_n=%b, required 0 and 1", starts - s0, bus.opll_cs_n); end
  endtask

  task automatic test_fill();
    int s0;
    s0 = starts;
    push(1'b0, 8'h55, 1'b1);
    release_req();
    wait_starts(s0 + 1, "fill");
    tick_en = 1'b0;
    for (int i = 0; i < 16; i++) push(1'(i % 2), 8'(8'hA0 + i), 1'b1);
    release_req();
    checks++; if (bus.fifo_level !== 5'd16 || bus.fifo_full !== 1'b1) begin errors++; $display("FAIL fill_16: got level=%0d full=%b, required 16/1", bus.fifo_level, bus.fifo_full); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_early: got %b, required 0", bus.overflow); end
    push(1'b1, 8'hB0, 1'b0);
    release_req();
    checks++; if (bus.fifo_level !== 5'd16 || bus.fifo_full !== 1'b1) begin errors++; $display("FAIL fill_drop_level: got level=%0d full=%b, required 16/1", bus.fifo_level, bus.fifo_full); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL fill_ovf: got %b, required 1", bus.overflow); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL fill_stuck_busy: got %b, required 1", bus.busy); end
    @(negedge clk); bus.ovf_clr = 1'b1;
    @(negedge clk); bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_clr: got %b, required 0", bus.overflow); end
  endtask

  task automatic test_full_pop();
    int n;
    tick_en = 1'b1;
    n = 0;
    while (bus.busy && n < 2000) begin @(negedge clk); n++; end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fpop_idle: got busy=%b, required 0", bus.busy); end
    bus.wr_req = 1'b1; bus.wr_a = 1'b1; bus.wr_data = 8'hEE;
    sb.push_back({1'b1, 8'hEE});
    release_req();
    checks++; if (bus.fifo_level !== 5'd16) begin errors++; $display("FAIL fpop_level: got %0d, required 16", bus.fifo_level); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL fpop_ovf: got %b, required 0", bus.overflow); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL fpop_busy: got %b, required 1", bus.busy); end
  endtask

  task automatic test_ovf_collision();
    push(1'b0, 8'h77, 1'b0);
    bus.ovf_clr = 1'b1;
    release_req();
    bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL coll_ovf: got %b, required 1", bus.overflow); end
    checks++; if (bus.fifo_level !== 5'd16) begin errors++; $display("FAIL coll_level: got %0d, required 16", bus.fifo_level); end
    @(negedge clk); bus.ovf_clr = 1'b1;
    @(negedge clk); bus.ovf_clr = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL coll_clr: got %b, required 0", bus.overflow); end
  endtask

  task automatic test_drain();
    wait_idle(20000, "drain");
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL drain_pending: got %0d unreplayed, required 0", sb.size()); end
    checks++; if (bus.fifo_full !== 1'b0 || bus.fifo_level !== 5'd0) begin errors++; $display("FAIL drain_level: got level=%0d full=%b, required 0/0", bus.fifo_level, bus.fifo_full); end
  endtask

  initial begin
    bus.wr_req = 1'b0; bus.wr_a = 1'b0; bus.wr_data = 8'h00; bus.ovf_clr = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_reset_mid();
    test_fill();
    test_full_pop();
    test_ovf_collision();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/opll_write_scheduler.md
Name: opll_write_scheduler

Overview:
- Queues Z80 I/O writes to the OPLL (ports 7Ch/7Dh) and replays them to the opll core at the YM2413's required pace: 12 master-clock cycles after an address write, 84 after a data write.
- Sits between the denoised bus decode and the opll instance. The CPU can burst register writes without wait states, and the OPLL never sees a write inside its busy window.
- Runs on the 27 MHz system clock. A 3.58 MHz tick enable drives the pacing.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- STROBE_TICKS, 2, number of 3.58 MHz ticks that opll_cs_n is held low per write.
- ADDR_WAIT, 12, ticks from the start of an address strobe to the next allowed strobe.
- DATA_WAIT, 84, ticks from the start of a data strobe to the next allowed strobe.

Ports:
- clk, in, 1, 27 MHz system clock; all logic on its rising edge.
- reset_n, in, 1, asynchronous active-low reset.
- tick_3m6, in, 1, one-clk-wide pulse per OPLL master-clock period (rising edge of the denoised bus clock).
- wr_req, in, 1, one-clk pulse for each completed CPU write cycle to 7Ch/7Dh.
- wr_a, in, 1, bus_addr[0] of that write: 0 = register address, 1 = register data.
- wr_data, in, 8, bus data of that write.
- ovf_clr, in, 1, clears the overflow flag.
- opll_cs_n, out, 1, chip select to the opll core.
- opll_a, out, 1, address select to the opll core.
- opll_d, out, 8, data to the opll core.
- busy, out, 1, high whenever the state machine is not IDLE.
- fifo_level, out, $clog2(DEPTH)+1, current occupancy, 0..DEPTH.
- fifo_full, out, 1, fifo_level == DEPTH.
- overflow, out, 1, sticky; set when a write is dropped.

Behaviour:
- Reset (asynchronous, reset_n = 0), all held while reset_n is low:
  - opll_cs_n = 1, opll_a = 0, opll_d = 0x00.
  - busy = 0, fifo_level = 0, fifo_full = 0, overflow = 0.
  - FIFO pointers = 0, state = IDLE, counter = 0.
- Reset mid-operation aborts any strobe in progress and discards queued entries.
- FIFO:
  - Each entry is {wr_a, wr_data}, 9 bits; ordering is strict FIFO.
  - Push on wr_req when not full.
  - Pop happens only in IDLE when fifo_level != 0.
  - Push while full with a pop in the same clk: push accepted, level stays DEPTH.
  - Push while full without a pop: entry dropped, level unchanged, overflow <= 1.
  - Simultaneous push and pop at any other level: level unchanged.
  - Pointers wrap modulo DEPTH.
- overflow: ovf_clr clears it in the clk after it is asserted. If a drop and ovf_clr occur in the same clk, set wins.
- IDLE state:
  - busy = 0, opll_cs_n = 1.
  - If fifo_level != 0: pop the head, load opll_a/opll_d from it, drive opll_cs_n = 0 and go to STROBE, all in the same clk edge.
  - Latency: a wr_req into an empty FIFO with IDLE state gives opll_cs_n low 2 clks after wr_req is sampled (push edge, then pop edge).
  - The pop does not wait for tick_3m6.
- STROBE state:
  - opll_cs_n = 0; opll_a and opll_d are stable.
  - The tick counter counts tick_3m6 pulses, starting at 0 on entry.
  - On the tick that brings the count to STROBE_TICKS: opll_cs_n <= 1 and go to WAIT. The counter continues and is not reset.
- WAIT state:
  - opll_cs_n = 1; opll_a and opll_d hold their last values.
  - Limit = ADDR_WAIT if the latched opll_a == 0, otherwise DATA_WAIT.
  - When the count reaches the limit: counter <= 0, go to IDLE.
  - The next strobe can start in the clk after IDLE is entered.
- Spacing guarantee: the start of consecutive strobes is separated by at least the limit in tick_3m6 pulses. Pulses that arrive in the IDLE clk are not counted.
- Arithmetic:
  - Counter is 7 bits, saturating; it never wraps.
  - If a wait parameter is less than STROBE_TICKS, the wait is treated as STROBE_TICKS.
- tick_3m6 stuck low: the block remains in STROBE/WAIT indefinitely. The FIFO keeps accepting writes until full.
- wr_a/wr_data are sampled only when wr_req = 1.

Test Plan:
- Reset mid-strobe: push {0,0x10}, assert reset_n = 0 while opll_cs_n = 0 -> opll_cs_n = 1, busy = 0 and fifo_level = 0 immediately (asynchronous); no strobe occurs after release.
- Single address write: wr_req with wr_a = 0, wr_data = 0x30, FIFO empty -> opll_cs_n low 2 clks later for exactly 2 ticks, opll_a = 0, opll_d = 0x30; busy deasserts after tick 12.
- Address then data burst: push {0,0x30} then {1,0x1F} on consecutive clks -> the second strobe starts 12 ticks after the first. Then push {0,0x10} -> its strobe starts 84 ticks after the data strobe.
- Fill with DEPTH = 16 while tick_3m6 is stopped: push 17 writes -> fifo_full = 1, overflow = 1, level = 16. Restart ticks -> the first 16 entries are replayed in order and the 17th never appears. ovf_clr -> overflow = 0.
- Full push with same-clk pop: hold the FIFO full at the IDLE pop clk and pulse wr_req -> level stays 16, overflow stays 0, and the new entry is replayed last.
- Overflow set/clear collision: drop a write in the same clk as ovf_clr -> overflow reads 1 on the next clk.
